// File: rtl/scanner_panel_pkg.sv
// Shared encodings and constants for the scanner operator-panel front end.
package scanner_panel_pkg;

  // Button debounce FSM states
  typedef enum logic [1:0] {
    BTN_IDLE         = 2'd0,
    BTN_PRESS_WAIT   = 2'd1,
    BTN_PRESSED      = 2'd2,
    BTN_RELEASE_WAIT = 2'd3
  } btn_state_t;

  // Interlock latch FSM states
  typedef enum logic [1:0] {
    ILK_SAFE     = 2'd0,
    ILK_TRIPPED  = 2'd1,
    ILK_HOLD     = 2'd2,
    ILK_WAIT_ACK = 2'd3
  } ilk_state_t;

  localparam logic [7:0] START_COUNT_MAX = 8'd255;

  // Saturating increment for the accepted-start counter
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    if (value == START_COUNT_MAX) begin
      return value;
    end else begin
      return value + 8'd1;
    end
  endfunction

endpackage

// File: rtl/scanner_sync_debounce.sv
// Input synchroniser followed by a four-state button debouncer.
// press_event is a one-cycle decode of the PRESS_WAIT->PRESSED transition,
// so the consumer registers it on the same edge that sets the level.
module scanner_sync_debounce
  import scanner_panel_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic din_raw,
  output logic level,
  output logic press_event
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   din_s;
  btn_state_t             state_r;
  btn_state_t             state_next_s;
  logic [CNT_W-1:0]       cnt_r;
  logic [CNT_W-1:0]       cnt_next_s;
  logic                   level_r;
  logic                   level_next_s;
  logic                   press_s;

  // Shift the raw input through the synchroniser chain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], din_raw};
    end
  end

  assign din_s = sync_r[SYNC_STAGES-1];

  // Debounce state, counter and level registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= BTN_IDLE;
      cnt_r   <= '0;
      level_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      level_r <= level_next_s;
    end
  end

  // Next-state decode; the press event fires only on entry to PRESSED
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    level_next_s = level_r;
    press_s      = 1'b0;
    case (state_r)
      BTN_IDLE: begin
        if (din_s) begin
          state_next_s = BTN_PRESS_WAIT;
          cnt_next_s   = CNT_ONE;
        end else begin
          state_next_s = BTN_IDLE;
        end
      end
      BTN_PRESS_WAIT: begin
        if (!din_s) begin
          state_next_s = BTN_IDLE;
        end else if (cnt_r == CNT_MAX) begin
          state_next_s = BTN_PRESSED;
          level_next_s = 1'b1;
          press_s      = 1'b1;
        end else begin
          cnt_next_s = cnt_r + CNT_ONE;
        end
      end
      BTN_PRESSED: begin
        if (!din_s) begin
          state_next_s = BTN_RELEASE_WAIT;
          cnt_next_s   = CNT_ONE;
        end else begin
          state_next_s = BTN_PRESSED;
        end
      end
      BTN_RELEASE_WAIT: begin
        if (din_s) begin
          // bounce back to held: no new press event
          state_next_s = BTN_PRESSED;
        end else if (cnt_r == CNT_MAX) begin
          state_next_s = BTN_IDLE;
          level_next_s = 1'b0;
        end else begin
          cnt_next_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_next_s = BTN_IDLE;
        cnt_next_s   = '0;
        level_next_s = 1'b0;
      end
    endcase
  end

  assign level       = level_r;
  assign press_event = press_s;

endmodule

// File: rtl/scanner_input_conditioner.sv
// Operator-panel front end: debounced start button gated by a latched,
// fail-safe interlock that needs a quiet hold time plus an operator ack.
module scanner_input_conditioner
  import scanner_panel_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int INTERLOCK_HOLD  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_raw,
  input  logic       interlock_raw,
  input  logic       ack_clear,
  output logic       op_start_pulse,
  output logic       interlock_sig,
  output logic       btn_level,
  output logic       start_reject,
  output logic [7:0] start_count
);

  localparam int HCNT_W = $clog2(INTERLOCK_HOLD + 1);
  localparam logic [HCNT_W-1:0] HCNT_ONE = HCNT_W'(1);
  localparam logic [HCNT_W-1:0] HCNT_MAX = HCNT_W'(INTERLOCK_HOLD);

  logic                   press_event_s;
  logic [SYNC_STAGES-1:0] ilk_sync_r;
  logic                   ilk_s;
  ilk_state_t             ilk_state_r;
  ilk_state_t             ilk_state_next_s;
  logic [HCNT_W-1:0]      hcnt_r;
  logic [HCNT_W-1:0]      hcnt_next_s;
  logic                   interlock_sig_r;
  logic                   pulse_r;
  logic                   reject_r;
  logic [7:0]             count_r;

  scanner_sync_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk        (clk),
    .reset      (reset),
    .din_raw    (btn_raw),
    .level      (btn_level),
    .press_event(press_event_s)
  );

  // Synchronise the raw interlock line
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ilk_sync_r <= '0;
    end else begin
      ilk_sync_r <= {ilk_sync_r[SYNC_STAGES-2:0], interlock_raw};
    end
  end

  assign ilk_s = ilk_sync_r[SYNC_STAGES-1];

  // Interlock next-state decode; a re-trip always beats an acknowledge
  always_comb begin
    ilk_state_next_s = ilk_state_r;
    hcnt_next_s      = hcnt_r;
    case (ilk_state_r)
      ILK_SAFE: begin
        if (ilk_s) begin
          ilk_state_next_s = ILK_TRIPPED;
        end else begin
          ilk_state_next_s = ILK_SAFE;
        end
      end
      ILK_TRIPPED: begin
        if (!ilk_s) begin
          ilk_state_next_s = ILK_HOLD;
          hcnt_next_s      = HCNT_ONE;
        end else begin
          ilk_state_next_s = ILK_TRIPPED;
        end
      end
      ILK_HOLD: begin
        if (ilk_s) begin
          ilk_state_next_s = ILK_TRIPPED;
        end else if (hcnt_r == HCNT_MAX) begin
          ilk_state_next_s = ILK_WAIT_ACK;
        end else begin
          hcnt_next_s = hcnt_r + HCNT_ONE;
        end
      end
      ILK_WAIT_ACK: begin
        if (ilk_s) begin
          ilk_state_next_s = ILK_TRIPPED;
        end else if (ack_clear) begin
          ilk_state_next_s = ILK_SAFE;
        end else begin
          ilk_state_next_s = ILK_WAIT_ACK;
        end
      end
      default: begin
        ilk_state_next_s = ILK_WAIT_ACK;
        hcnt_next_s      = '0;
      end
    endcase
  end

  // Interlock state register; the output is decoded from the next state so
  // it changes on the same edge as the state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ilk_state_r     <= ILK_WAIT_ACK;
      hcnt_r          <= '0;
      interlock_sig_r <= 1'b1;
    end else begin
      ilk_state_r     <= ilk_state_next_s;
      hcnt_r          <= hcnt_next_s;
      interlock_sig_r <= (ilk_state_next_s != ILK_SAFE);
    end
  end

  // Gate each press event on the interlock level currently presented
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pulse_r  <= 1'b0;
      reject_r <= 1'b0;
      count_r  <= 8'd0;
    end else if (press_event_s) begin
      if (!interlock_sig_r) begin
        pulse_r  <= 1'b1;
        reject_r <= 1'b0;
        count_r  <= sat_inc8(count_r);
      end else begin
        pulse_r  <= 1'b0;
        reject_r <= 1'b1;
      end
    end else begin
      pulse_r  <= 1'b0;
      reject_r <= 1'b0;
    end
  end

  assign op_start_pulse = pulse_r;
  assign start_reject   = reject_r;
  assign start_count    = count_r;
  assign interlock_sig  = interlock_sig_r;

endmodule

// File: tb/tb_scanner_input_conditioner.sv
// Directed bench for scanner_input_conditioner with default parameters.
module tb_scanner_input_conditioner;

  logic       clk;
  logic       reset;
  logic       btn_raw;
  logic       interlock_raw;
  logic       ack_clear;
  logic       op_start_pulse;
  logic       interlock_sig;
  logic       btn_level;
  logic       start_reject;
  logic [7:0] start_count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       btn;
    logic       ilk;
    logic       ack;
    int         cycles;
    logic       e_ilk;
    logic       e_lvl;
    logic [7:0] e_cnt;
    int         e_pul;
    int         e_rej;
  } vec_t;

  vec_t vecs[24];

  scanner_input_conditioner dut (
    .clk           (clk),
    .reset         (reset),
    .btn_raw       (btn_raw),
    .interlock_raw (interlock_raw),
    .ack_clear     (ack_clear),
    .op_start_pulse(op_start_pulse),
    .interlock_sig (interlock_sig),
    .btn_level     (btn_level),
    .start_reject  (start_reject),
    .start_count   (start_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int pul;
    int rej;
    pul = 0;
    rej = 0;
    btn_raw       = v.btn;
    interlock_raw = v.ilk;
    ack_clear     = v.ack;
    for (int k = 0; k < v.cycles; k++) begin
      tick();
      pul += int'(op_start_pulse);
      rej += int'(start_reject);
    end
    check($sformatf("v%0d_interlock_sig", idx), int'(interlock_sig), int'(v.e_ilk));
    check($sformatf("v%0d_btn_level", idx), int'(btn_level), int'(v.e_lvl));
    check($sformatf("v%0d_start_count", idx), int'(start_count), int'(v.e_cnt));
    check($sformatf("v%0d_pulses", idx), pul, v.e_pul);
    check($sformatf("v%0d_rejects", idx), rej, v.e_rej);
  endtask

  initial begin
    int exp_cnt;
    int pulses;

    //           btn   ilk   ack  cyc  ilk   lvl   cnt  pul rej
    // reset release: stays latched until acked
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 3,  1'b1, 1'b0, 8'd0, 0, 0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 1,  1'b0, 1'b0, 8'd0, 0, 0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 2,  1'b0, 1'b0, 8'd0, 0, 0};
    // clean 40-cycle press, then release: level drops on the 19th tick
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 40, 1'b0, 1'b1, 8'd1, 1, 0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 17, 1'b0, 1'b1, 8'd1, 0, 0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 2,  1'b0, 1'b0, 8'd1, 0, 0};
    // bounce 5 high / 3 low, four times, then quiet
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 5,  1'b0, 1'b0, 8'd1, 0, 0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 3,  1'b0, 1'b0, 8'd1, 0, 0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 5,  1'b0, 1'b0, 8'd1, 0, 0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 3,  1'b0, 1'b0, 8'd1, 0, 0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 5,  1'b0, 1'b0, 8'd1, 0, 0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 3,  1'b0, 1'b0, 8'd1, 0, 0};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 5,  1'b0, 1'b0, 8'd1, 0, 0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 3,  1'b0, 1'b0, 8'd1, 0, 0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 20, 1'b0, 1'b0, 8'd1, 0, 0};
    // 1-cycle interlock glitch: latched on the 3rd edge, ack in HOLD ignored
    vecs[15] = '{1'b0, 1'b1, 1'b0, 1,  1'b0, 1'b0, 8'd1, 0, 0};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 2,  1'b1, 1'b0, 8'd1, 0, 0};
    vecs[17] = '{1'b0, 1'b0, 1'b1, 3,  1'b1, 1'b0, 8'd1, 0, 0};
    // press while latched is rejected, release, then ack clears
    vecs[18] = '{1'b1, 1'b0, 1'b0, 20, 1'b1, 1'b1, 8'd1, 0, 1};
    vecs[19] = '{1'b0, 1'b0, 1'b0, 20, 1'b1, 1'b0, 8'd1, 0, 0};
    vecs[20] = '{1'b0, 1'b0, 1'b1, 1,  1'b0, 1'b0, 8'd1, 0, 0};
    vecs[21] = '{1'b0, 1'b0, 1'b0, 1,  1'b0, 1'b0, 8'd1, 0, 0};
    // press after clearing is accepted
    vecs[22] = '{1'b1, 1'b0, 1'b0, 20, 1'b0, 1'b1, 8'd2, 1, 0};
    vecs[23] = '{1'b0, 1'b0, 1'b0, 20, 1'b0, 1'b0, 8'd2, 0, 0};

    reset         = 1'b0;
    btn_raw       = 1'b0;
    interlock_raw = 1'b0;
    ack_clear     = 1'b0;
    repeat (3) tick();
    check("rst_interlock_sig", int'(interlock_sig), 1);
    check("rst_op_start_pulse", int'(op_start_pulse), 0);
    check("rst_start_reject", int'(start_reject), 0);
    check("rst_btn_level", int'(btn_level), 0);
    check("rst_start_count", int'(start_count), 0);
    reset = 1'b1;

    for (int i = 0; i < 24; i++) begin
      run_vec(vecs[i], i);
    end

    // exact press latency: pulse only on the 19th tick after driving high
    btn_raw = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 18) check("lat_pulse_t18", int'(op_start_pulse), 0);
      if (k == 19) check("lat_pulse_t19", int'(op_start_pulse), 1);
      if (k == 20) check("lat_pulse_t20", int'(op_start_pulse), 0);
    end
    btn_raw = 1'b0;
    repeat (20) tick();
    check("lat_count", int'(start_count), 3);

    // interlock rise timing and retrip restarting the hold count
    interlock_raw = 1'b1;
    tick();
    tick();
    check("ilk_rise_t2", int'(interlock_sig), 0);
    tick();
    check("ilk_rise_t3", int'(interlock_sig), 1);
    repeat (2) tick();
    interlock_raw = 1'b0;
    repeat (5) tick();
    interlock_raw = 1'b1;
    repeat (4) tick();
    check("retrip_sig", int'(interlock_sig), 1);
    interlock_raw = 1'b0;
    ack_clear     = 1'b1;
    repeat (11) tick();
    check("retrip_hold_t11", int'(interlock_sig), 1);
    tick();
    check("retrip_hold_t12", int'(interlock_sig), 0);
    ack_clear = 1'b0;
    tick();

    // 260 accepted presses: counter saturates while pulses keep coming
    exp_cnt = 3;
    pulses  = 0;
    for (int p = 0; p < 260; p++) begin
      btn_raw = 1'b1;
      repeat (20) begin
        tick();
        pulses += int'(op_start_pulse);
      end
      btn_raw = 1'b0;
      repeat (20) tick();
      exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
      check($sformatf("sat_count_p%0d", p), int'(start_count), exp_cnt);
    end
    check("sat_pulses", pulses, 260);

    // asynchronous reset in the middle of a pulse
    btn_raw = 1'b1;
    repeat (19) tick();
    check("midrst_pulse_before", int'(op_start_pulse), 1);
    check("midrst_level_before", int'(btn_level), 1);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_interlock_sig", int'(interlock_sig), 1);
    check("midrst_op_start_pulse", int'(op_start_pulse), 0);
    check("midrst_start_reject", int'(start_reject), 0);
    check("midrst_btn_level", int'(btn_level), 0);
    check("midrst_start_count", int'(start_count), 0);
    tick();
    btn_raw = 1'b0;
    reset   = 1'b1;
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scanner_input_conditioner.md
Name: scanner_input_conditioner

Overview:
Operator-panel front end that sits directly upstream of the scanner top level. It takes the raw start button and the raw safety interlock line, synchronises both, and debounces the button. It produces the single-cycle start request and the latched, fail-safe interlock level that drive the top's op_start_btn and interlock_sig inputs. The interlock clears only after the raw line has stayed quiet for a hold time and the operator has acknowledged.

Parameters:
SYNC_STAGES, 2, flip-flop depth of each input synchroniser (minimum 2)
DEBOUNCE_CYCLES, 16, number of consecutive stable synchronised cycles needed to accept a button press or release (minimum 1)
INTERLOCK_HOLD, 8, number of consecutive clear cycles on the synchronised interlock before an acknowledge is accepted (minimum 1)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
btn_raw  input  1  asynchronous start button, 1 = pressed
interlock_raw  input  1  asynchronous safety sensor, 1 = unsafe
ack_clear  input  1  synchronous operator acknowledge, level-sampled
op_start_pulse  output  1  one-cycle accepted start request, goes to op_start_btn
interlock_sig  output  1  latched interlock, 1 = halt, goes to interlock_sig
btn_level  output  1  debounced button level
start_reject  output  1  one-cycle pulse: debounced press arrived while interlock_sig=1
start_count  output  8  accepted starts, saturating at 255

Behaviour:
- Clocking and reset
  - Single clock domain: clk.
  - reset is asynchronous and active-low. All flops clear immediately when reset=0.
- Reset values
  - op_start_pulse=0, start_reject=0, btn_level=0, start_count=0.
  - Synchroniser flops=0.
  - interlock_sig=1 (fail-safe). The interlock FSM resets into WAIT_ACK.
- Synchronisers
  - Each raw input passes through SYNC_STAGES flops before any use; call the outputs btn_s and ilk_s.
- Button FSM
  - States: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
  - The debounce counter is $clog2(DEBOUNCE_CYCLES+1) bits wide.
  - IDLE: btn_s=1 -> PRESS_WAIT with cnt=1.
  - PRESS_WAIT: btn_s=0 -> IDLE. Otherwise, if cnt==DEBOUNCE_CYCLES -> PRESSED; else cnt+1.
  - Entering PRESSED sets btn_level=1 and raises the press event for exactly one cycle.
  - PRESSED: btn_s=0 -> RELEASE_WAIT with cnt=1.
  - RELEASE_WAIT: btn_s=1 -> PRESSED, with no new press event. Otherwise, if cnt==DEBOUNCE_CYCLES -> IDLE and btn_level=0; else cnt+1.
- Press event handling
  - If interlock_sig=0 in the cycle the event is registered: op_start_pulse=1 for that one cycle, and start_count increments (holds at 255).
  - If interlock_sig=1: start_reject=1 for one cycle, no op_start_pulse, count unchanged.
  - A held button never produces a second pulse. A new pulse requires a full release (return to IDLE) first.
- Latency
  - btn_raw first sampled high at edge N and held stable -> op_start_pulse high in the cycle after edge N+SYNC_STAGES+DEBOUNCE_CYCLES (18 cycles with defaults).
- Interlock FSM
  - States: SAFE, TRIPPED, HOLD, WAIT_ACK.
  - interlock_sig = (state != SAFE), registered.
  - SAFE: ilk_s=1 -> TRIPPED. interlock_sig rises SYNC_STAGES+1 edges after raw assertion.
  - TRIPPED: ilk_s=0 -> HOLD with hcnt=1.
  - HOLD: ilk_s=1 -> TRIPPED. hcnt==INTERLOCK_HOLD -> WAIT_ACK. Otherwise hcnt+1.
  - WAIT_ACK: ilk_s=1 -> TRIPPED (has priority over ack). ack_clear=1 -> SAFE.
  - ack_clear is ignored in SAFE, TRIPPED and HOLD. An early ack is not remembered.
- Simultaneous events
  - Press event and a SAFE->TRIPPED transition in the same cycle: the pulse decision uses the current registered interlock_sig, so the start is accepted.
  - Press event and a WAIT_ACK->SAFE transition in the same cycle: rejected.
- Reset mid-operation
  - Any FSM in any state returns to its reset state. A pulse in flight is dropped, and start_count clears.

Decomposition:
- Shared package scanner_panel_pkg holds:
  - the button state encoding (2 bits);
  - the interlock state encoding (2 bits);
  - the START_COUNT_MAX=255 constant.
- One sub-module is natural: scanner_sync_debounce.
  - Contents: synchroniser plus button FSM, parameterised by SYNC_STAGES and DEBOUNCE_CYCLES.
  - Outputs: level and press event.
  - The interlock FSM and start gating stay in the top.

Test Plan:
1. Reset release with interlock_raw=0, no ack -> interlock_sig stays 1. Pulse ack_clear after edge 3 (ilk_s settled 0, FSM in WAIT_ACK) -> interlock_sig=0 on the next edge.
2. Cleared interlock, btn_raw held high 40 cycles -> exactly one op_start_pulse, 18 cycles after first sampling. start_count=1, btn_level=1 until 16 cycles after release settles.
3. btn_raw bounce: 5 cycles high, 3 low, repeated 4 times, then low -> no op_start_pulse, start_count=0, btn_level=0.
4. Assert interlock_raw for 1 cycle, then press the button -> interlock_sig=1, start_reject pulses once, no op_start_pulse. ack_clear during HOLD is ignored. ack_clear after 8 clear cycles -> interlock_sig=0.
5. Interlock retrip: raw clears for 5 cycles then re-asserts -> FSM returns to TRIPPED, and the hold count restarts from 1 on the next clear.
6. 260 accepted presses -> start_count saturates at 255. Drive reset=0 mid-press -> all outputs return to reset values asynchronously, with interlock_sig=1.
